// File: rtl/super_top.sv
// super_top: 640x480@60 VGA timing generator with a 32-bit nonce counter shown as bit columns or colour bars
module super_top #(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       btnd,
    input  logic [1:0] sw,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(PIX_DIV);
    localparam int HW = $clog2(H_TOT);
    localparam int VW = $clog2(V_TOT);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS_W  = HW'(H_VIS);
    localparam logic [VW-1:0] V_VIS_W  = VW'(V_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [HW-1:0] COL_W    = HW'(20);
    localparam logic [HW-1:0] SEP_POS  = HW'(19);
    localparam logic [HW-1:0] BAR_W    = HW'(80);

    logic          rst;
    logic [1:0]    sw_meta;
    logic [1:0]    sw_sync;
    logic [DW-1:0] div;
    logic          pe;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic [31:0]   nonce;
    logic          visible;
    logic [HW-1:0] col;
    logic [HW-1:0] col_pos;
    logic [HW-1:0] bar;
    logic          nonce_bit;
    logic [7:0]    bar_rgb;
    logic [7:0]    rgb_next;
    logic          hsync_next;
    logic          vsync_next;

    assign rst = btnd;

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Pixel-rate divider: pe fires on the last clk of each pixel period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else
            div <= pe ? '0 : div + 1'b1;
    end

    assign pe     = div == DIV_LAST;
    assign h_last = h == H_LAST;
    assign v_last = v == V_LAST;

    // Raster position: h advances each pixel, v advances when h wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            h <= h_last ? '0 : h + 1'b1;
            if (h_last)
                v <= v_last ? '0 : v + 1'b1;
        end
    end

    // Nonce advances once per frame on its last pixel when counting is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            nonce <= '0;
        else if (pe && h_last && v_last && sw_sync[0])
            nonce <= nonce + 32'd1;
    end

    // Pixel colour and sync levels for the current raster position
    always_comb begin
        visible    = (h < H_VIS_W) && (v < V_VIS_W);
        col        = h / COL_W;
        col_pos    = h % COL_W;
        bar        = h / BAR_W;
        nonce_bit  = nonce[~col[4:0]];
        bar_rgb    = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
        rgb_next   = !visible ? 8'h00 :
                     sw_sync[1] ? bar_rgb :
                     (col_pos == SEP_POS) ? 8'h00 :
                     nonce_bit ? 8'h1C : 8'hE0;
        hsync_next = !((h >= HS_FIRST) && (h <= HS_LAST));
        vsync_next = !((v >= VS_FIRST) && (v <= VS_LAST));
    end

    // Register the outputs on each pixel enable, one pixel behind the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 8'h00;
        end else if (pe) begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            rgb   <= rgb_next;
        end
    end
endmodule

// File: tb/tb_super_top.sv
// tb_super_top: randomized scoreboard bench for super_top with a shortened vertical raster
`timescale 1ns/1ps
module tb_super_top;
    localparam int VV = 2, VF = 1, VS = 1, VB = 1;
    localparam int VT = VV + VF + VS + VB;
    localparam int HT = 800;
    localparam int FRAME_CLKS = HT * VT * 4;

    logic       clk = 0;
    logic       btnd = 1;
    logic [1:0] sw = 2'b00;
    logic       hsync, vsync;
    logic [7:0] rgb;

    int compared = 0;
    int mismatched = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_cur;
    logic [31:0] nonce_m;
    logic [1:0] sw_h1, sw_h2;
    longint c;

    super_top #(.V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
        .clk(clk), .btnd(btnd), .sw(sw), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pixel(int h, int v, logic [31:0] n, logic mode);
        logic hs, vs;
        logic [7:0] col;
        logic [2:0] b;
        hs = !(h >= 656 && h <= 751);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        col = 8'h00;
        if (h < 640 && v < VV) begin
            if (mode) begin
                b = 3'(h / 80);
                col = {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
            end else if (h % 20 != 19) begin
                col = n[31 - h / 20] ? 8'h1C : 8'hE0;
            end
        end
        return {hs, vs, col};
    endfunction

    // Reference model: pixel p is the one registered at the (p+1)-th pixel enable after release
    always @(posedge clk) begin
        if (btnd) begin
            c = 0;
            nonce_m = 0;
            sw_h1 = 0;
            sw_h2 = 0;
            exp_cur = {1'b1, 1'b1, 8'h00};
        end else begin
            c++;
            if (c % 4 == 0) begin
                longint p;
                int hh, vv;
                p = c / 4 - 1;
                hh = int'(p % HT);
                vv = int'((p / HT) % VT);
                exp_cur = pixel(hh, vv, nonce_m, sw_h2[1]);
                if (hh == HT - 1 && vv == VT - 1 && sw_h2[0])
                    nonce_m = nonce_m + 1;
            end
            sw_h2 = sw_h1;
            sw_h1 = sw;
        end
        exp_q.push_back(exp_cur);
    end

    // Monitor: compare DUT outputs against the queued expectation away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            compared++;
            if ({hsync, vsync, rgb} !== e) begin
                mismatched++;
                $display("FAIL pix t=%0t got hs=%b vs=%b rgb=%h exp hs=%b vs=%b rgb=%h",
                         $time, hsync, vsync, rgb, e[9], e[8], e[7:0]);
            end
        end
    end

    task automatic check_nonce(string tag);
        compared++;
        if (dut.nonce !== nonce_m) begin
            mismatched++;
            $display("FAIL nonce_%s got=%h exp=%h", tag, dut.nonce, nonce_m);
        end
    endtask

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        run(10 + $urandom_range(0, 10));
        check_nonce("reset");
        #2 btnd = 0;
        run(FRAME_CLKS + $urandom_range(100, 3000));
        check_nonce("sw00");
        #3 sw = 2'b01;
        run(2 * FRAME_CLKS);
        check_nonce("count2");
        #3 sw = 2'b10;
        run(FRAME_CLKS);
        check_nonce("hold");
        #3 sw = 2'b11;
        run(300 + $urandom_range(0, 600));
        #2 btnd = 1;
        #1;
        compared++;
        if ({hsync, vsync, rgb} !== 10'b11_0000_0000) begin
            mismatched++;
            $display("FAIL async_rst got hs=%b vs=%b rgb=%h exp hs=1 vs=1 rgb=00", hsync, vsync, rgb);
        end
        compared++;
        if (dut.nonce !== 32'd0) begin
            mismatched++;
            $display("FAIL async_rst_nonce got=%h exp=00000000", dut.nonce);
        end
        run(5 + $urandom_range(0, 10));
        #2 btnd = 0;
        sw = 2'b01;
        run(2 * HT * 4 + 50);
        check_nonce("after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
